// File: rtl/teng_link_sequencer.sv
// Bring-up and recovery sequencer for the 10G PHY/MAC pair: PHY reset, PMA-ready wait,
// per-lane link wait, link supervision and bounded retry with a parked FAIL state.
module teng_link_sequencer #(
  parameter int unsigned NUMBER_OF_LANES = 2,
  parameter int unsigned RST_CYCLES      = 1000,
  parameter int unsigned PMA_TIMEOUT     = 100000,
  parameter int unsigned LINK_TIMEOUT    = 1000000,
  parameter int unsigned DROP_CYCLES     = 64,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_reset_i,
  input  logic                       restart_i,
  input  logic                       pma_tx_ready_i,
  input  logic                       pma_rx_ready_i,
  input  logic [NUMBER_OF_LANES-1:0] link_up_i,
  output logic                       phy_reset_o,
  output logic                       mac_reset_o,
  output logic                       link_ok_o,
  output logic                       fail_o,
  output logic [3:0]                 retry_cnt_o,
  output logic [2:0]                 state_o
);

  typedef enum logic [2:0] {
    ST_PHY_RST   = 3'd0,
    ST_WAIT_PMA  = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_UP        = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int unsigned MAX_AB = (RST_CYCLES > PMA_TIMEOUT) ? RST_CYCLES : PMA_TIMEOUT;
  localparam int unsigned MAX_CD = (LINK_TIMEOUT > DROP_CYCLES) ? LINK_TIMEOUT : DROP_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = $clog2(MAX_C) + 1;
  localparam int unsigned SYNC_W = NUMBER_OF_LANES + 2;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [SYNC_W-1:0]  sync1_q, sync2_q;
  logic               phy_reset_q, mac_reset_q, link_ok_q, fail_q;
  logic               rdy, all_up, fail_ev;

  always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pma_tx_ready_i, pma_rx_ready_i, link_up_i};
      sync2_q <= sync1_q;
    end
  end

  assign rdy    = sync2_q[SYNC_W-1] & sync2_q[SYNC_W-2];
  assign all_up = &sync2_q[NUMBER_OF_LANES-1:0];

  // In UP the cycle counter doubles as the consecutive-drop counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d = retry_q;
    fail_ev = 1'b0;
    if (restart_i) begin
      state_d = ST_PHY_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PHY_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_PMA;
            cnt_d   = '0;
          end
        end
        ST_WAIT_PMA: begin
          if (rdy) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
          end else if (cnt_q == PMA_LAST) begin
            fail_ev = 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          if (all_up) begin
            state_d = ST_UP;
            cnt_d   = '0;
            retry_d = '0;
          end else if (!rdy || cnt_q == LINK_LAST) begin
            fail_ev = 1'b1;
          end
        end
        ST_UP: begin
          if (!rdy) begin
            fail_ev = 1'b1;
          end else if (all_up) begin
            cnt_d = '0;
          end else if (cnt_q == DROP_LAST) begin
            fail_ev = 1'b1;
          end
        end
        ST_FAIL: cnt_d = cnt_q;
        default: begin
          state_d = ST_PHY_RST;
          cnt_d   = '0;
        end
      endcase
    end
    if (fail_ev) begin
      cnt_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = ST_PHY_RST;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      state_q     <= ST_PHY_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      phy_reset_q <= 1'b1;
      mac_reset_q <= 1'b1;
      link_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      phy_reset_q <= (state_d == ST_PHY_RST) || (state_d == ST_FAIL);
      mac_reset_q <= (state_d == ST_PHY_RST) || (state_d == ST_WAIT_PMA);
      link_ok_q   <= (state_d == ST_UP);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign phy_reset_o = phy_reset_q;
  assign mac_reset_o = mac_reset_q;
  assign link_ok_o   = link_ok_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_teng_link_sequencer.sv
// Bench for teng_link_sequencer: directed vector table, hand-written corner sequences and
// a randomized run, all checked cycle by cycle against a rule-level reference model.
module tb_teng_link_sequencer;
  localparam int RST_C = 16;
  localparam int PMA_T = 100;
  localparam int LINK_T = 200;
  localparam int DROP_C = 8;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst, restart, tx, rx;
  logic [1:0] link;
  logic       phy_reset, mac_reset, link_ok, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  teng_link_sequencer #(
    .NUMBER_OF_LANES(2), .RST_CYCLES(RST_C), .PMA_TIMEOUT(PMA_T),
    .LINK_TIMEOUT(LINK_T), .DROP_CYCLES(DROP_C), .MAX_RETRIES(MAXR)
  ) dut (
    .sys_clk_i(clk), .sys_reset_i(rst), .restart_i(restart),
    .pma_tx_ready_i(tx), .pma_rx_ready_i(rx), .link_up_i(link),
    .phy_reset_o(phy_reset), .mac_reset_o(mac_reset), .link_ok_o(link_ok),
    .fail_o(fail), .retry_cnt_o(retry_cnt), .state_o(state)
  );

  // Reference model: 0 PHY_RST, 1 WAIT_PMA, 2 WAIT_LINK, 3 UP, 4 FAIL
  int m_state, m_cnt, m_retry;
  logic [3:0] m_hist[2]; // {tx, rx, link} delayed by the two-stage synchroniser

  function automatic logic [10:0] expect_of(int st, int rt);
    return {3'(st), 4'(rt), (st == 0 || st == 4), (st <= 1), (st == 3), (st == 4)};
  endfunction

  function automatic logic [10:0] actual();
    return {state, retry_cnt, phy_reset, mac_reset, link_ok, fail};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got st=%0d rt=%0d phy/mac/ok/fail=%b required st=%0d rt=%0d phy/mac/ok/fail=%b",
               name, $time, act[10:8], act[7:4], act[3:0], exp[10:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_retry = 0;
    m_hist[0] = '0; m_hist[1] = '0;
  endtask

  task automatic model_edge();
    logic rdy, up, ev;
    int ns, nc, nr;
    rdy = m_hist[1][3] & m_hist[1][2];
    up  = (m_hist[1][1:0] == 2'b11);
    ns = m_state; nc = m_cnt + 1; nr = m_retry; ev = 1'b0;
    if (restart) begin
      ns = 0; nc = 0; nr = 0;
    end else if (m_state == 0) begin
      if (m_cnt == RST_C - 1) begin ns = 1; nc = 0; end
    end else if (m_state == 1) begin
      if (rdy) begin ns = 2; nc = 0; end
      else if (m_cnt == PMA_T - 1) ev = 1'b1;
    end else if (m_state == 2) begin
      if (up) begin ns = 3; nc = 0; nr = 0; end
      else if (!rdy || m_cnt == LINK_T - 1) ev = 1'b1;
    end else if (m_state == 3) begin
      if (!rdy) ev = 1'b1;
      else if (up) nc = 0;
      else if (m_cnt == DROP_C - 1) ev = 1'b1;
    end else begin
      nc = m_cnt;
    end
    if (ev) begin
      nc = 0;
      if (m_retry < MAXR) begin nr = m_retry + 1; ns = 0; end
      else ns = 4;
    end
    m_state = ns; m_cnt = nc; m_retry = nr;
    m_hist[1] = m_hist[0];
    m_hist[0] = {tx, rx, link};
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("model", actual(), expect_of(m_state, m_retry));
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; tx = 1'b0; rx = 1'b0; link = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_values", actual(), expect_of(0, 0));
    rst = 1'b0;
  endtask

  typedef struct {
    bit         do_rst;
    logic       rs;
    logic       tx;
    logic       rx;
    logic [1:0] lk;
    int         n;
    int         st;
    int         rt;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit d, logic r, logic t, logic x, logic [1:0] l, int n, int st, int rt);
    vec_t v;
    v.do_rst = d; v.rs = r; v.tx = t; v.rx = x; v.lk = l; v.n = n; v.st = st; v.rt = rt;
    return v;
  endfunction

  initial begin
    rst = 1'b1; restart = 1'b0; tx = 1'b0; rx = 1'b0; link = 2'b00;
    model_reset();

    // clean bring-up, drop debounce, ready loss, restart
    tab.push_back(mk(1, 0, 0, 0, 2'b00, 15, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 2'b00,  1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 14, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b00,  2, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b00,  1, 2, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b00, 27, 2, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  2, 2, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b01,  7, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 10, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b01,  8, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  2, 0, 1));
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 16, 1, 1));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 2, 1));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 3, 0));
    tab.push_back(mk(0, 0, 1, 0, 2'b11,  1, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 3, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 0, 1));
    tab.push_back(mk(0, 1, 1, 1, 2'b11,  1, 0, 0));
    // PMA never ready: retries exhaust into FAIL, FAIL ignores inputs, restart leaves it
    tab.push_back(mk(1, 0, 0, 0, 2'b00, 16, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 99, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 2'b00,  1, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 16, 1, 1));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 100, 0, 2));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 16, 1, 2));
    tab.push_back(mk(0, 0, 0, 0, 2'b00, 100, 4, 2));
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 50, 4, 2));
    tab.push_back(mk(0, 1, 1, 1, 2'b11,  1, 0, 0));
    // restart beats link completion; restart inside PHY_RST restarts the count
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 16, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 2, 0));
    tab.push_back(mk(0, 1, 1, 1, 2'b11,  1, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 10, 0, 0));
    tab.push_back(mk(0, 1, 1, 1, 2'b11,  1, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11, 15, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 2'b11,  1, 1, 0));

    foreach (tab[i]) begin
      if (tab[i].do_rst) do_reset();
      restart = tab[i].rs; tx = tab[i].tx; rx = tab[i].rx; link = tab[i].lk;
      for (int c = 0; c < tab[i].n; c++) tick();
      chk($sformatf("table_row%0d", i), actual(), expect_of(tab[i].st, tab[i].rt));
    end
    restart = 1'b0;

    // asynchronous reset in the middle of WAIT_LINK
    do_reset();
    tx = 1'b1; rx = 1'b1; link = 2'b00;
    for (int c = 0; c < 17; c++) tick();
    chk("reach_wait_link", actual(), expect_of(2, 0));
    rst = 1'b1;
    #1;
    chk("async_reset_mid", actual(), expect_of(0, 0));
    model_reset();
    tx = 1'b0; rx = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // randomized run
    tx = 1'b1; rx = 1'b1; link = 2'b11;
    for (int c = 0; c < 6000; c++) begin
      if (tx) tx = ($urandom_range(199) != 0); else tx = ($urandom_range(7) == 0);
      if (rx) rx = ($urandom_range(199) != 0); else rx = ($urandom_range(7) == 0);
      for (int l = 0; l < 2; l++) begin
        if (link[l]) link[l] = ($urandom_range(59) != 0);
        else         link[l] = ($urandom_range(5) == 0);
      end
      restart = ($urandom_range(399) == 0);
      if ($urandom_range(2999) == 0) begin
        do_reset();
        tx = 1'b1; rx = 1'b1; link = 2'b11;
      end else begin
        tick();
      end
    end
    restart = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
